// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt unit: SR, Cause, EPC, PRId, M-stage entry and eret.
// Ports: clk/reset_n, M-stage pc/bd/exc, hw_int, mfc0/mtc0/eret, flush + vector.
// Optional CP0_TIMER_EN adds Count (9), Compare (11) and a timer interrupt on IP[15].
module cp0_exc_unit #(
  parameter logic [31:0] PRID       = 32'h0000_0001,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic [4:0]  cp0_addr,
  input  logic        cp0_we,
  input  logic [31:0] cp0_din,
  input  logic        eret,
  output logic [31:0] cp0_dout,
  output logic [31:0] epc_out,
  output logic        exc_req,
  output logic [31:0] handler_pc
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_SR      = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;

  logic [5:0]  sr_im_q,  sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q,  sr_ie_d;
  logic        bd_q,     bd_d;
  logic [5:0]  ip_q,     ip_d;
  logic [4:0]  code_q,   code_d;
  logic [31:0] epc_q,    epc_d;

  logic [5:0]  irq_lines;
  logic        int_pend;
  logic        exc_pend;
  logic        wr_ok;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;
  logic [31:0] count_rd;
  logic [31:0] compare_rd;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic        tpend_q,   tpend_d;

  // Timer interrupt takes over the top hardware line.
  assign irq_lines  = {tpend_q, hw_int[4:0]};
  assign count_rd   = count_q;
  assign compare_rd = compare_q;

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    tpend_d   = tpend_q;
    if (count_q == compare_q && compare_q != 32'd0)
      tpend_d = 1'b1;
    if (wr_ok && cp0_addr == A_COUNT)
      count_d = cp0_din;
    if (wr_ok && cp0_addr == A_COMPARE) begin
      compare_d = cp0_din;
      tpend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      compare_q <= '0;
      tpend_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tpend_q   <= tpend_d;
    end
  end
`else
  assign irq_lines  = hw_int;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  // Masking uses registered SR, so an mtc0 SR acts from the next cycle.
  assign int_pend = (|(irq_lines & sr_im_q)) & sr_ie_q & ~sr_exl_q;
  assign exc_pend = exc_valid & ~sr_exl_q;
  assign exc_req  = (int_pend | exc_pend) & reset_n;

  // A cancelled instruction must not commit its mtc0.
  assign wr_ok = cp0_we & ~exc_req;

  always_comb begin
    sr_im_d  = sr_im_q;
    sr_exl_d = sr_exl_q;
    sr_ie_d  = sr_ie_q;
    bd_d     = bd_q;
    ip_d     = irq_lines;
    code_d   = code_q;
    epc_d    = epc_q;
    if (exc_req) begin
      sr_exl_d = 1'b1;
      bd_d     = bd_m;
      code_d   = int_pend ? 5'd0 : exc_code;
      epc_d    = bd_m ? pc_m - 32'd4 : pc_m;
    end else begin
      if (wr_ok && cp0_addr == A_SR) begin
        sr_im_d  = cp0_din[15:10];
        sr_exl_d = cp0_din[1];
        sr_ie_d  = cp0_din[0];
      end
      if (wr_ok && cp0_addr == A_EPC)
        epc_d = {cp0_din[31:2], 2'b00};
      if (eret)
        sr_exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_im_q  <= '0;
      sr_exl_q <= 1'b0;
      sr_ie_q  <= 1'b0;
      bd_q     <= 1'b0;
      ip_q     <= '0;
      code_q   <= '0;
      epc_q    <= '0;
    end else begin
      sr_im_q  <= sr_im_d;
      sr_exl_q <= sr_exl_d;
      sr_ie_q  <= sr_ie_d;
      bd_q     <= bd_d;
      ip_q     <= ip_d;
      code_q   <= code_d;
      epc_q    <= epc_d;
    end
  end

  assign sr_rd = {16'd0, sr_im_q, 8'd0,
                  sr_exl_q, sr_ie_q};
  assign cause_rd = {bd_q, 15'd0, ip_q,
                     3'd0, code_q, 2'd0};

  always_comb begin
    cp0_dout = '0;
    case (cp0_addr)
      A_COUNT:   cp0_dout = count_rd;
      A_COMPARE: cp0_dout = compare_rd;
      A_SR:      cp0_dout = sr_rd;
      A_CAUSE:   cp0_dout = cause_rd;
      A_EPC:     cp0_dout = epc_q;
      A_PRID:    cp0_dout = PRID;
      default:   cp0_dout = '0;
    endcase
  end

  assign epc_out    = epc_q;
  assign handler_pc = EXC_VECTOR;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed testbench for cp0_exc_unit.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_din;
  logic        eret;
  logic [31:0] cp0_dout;
  logic [31:0] epc_out;
  logic        exc_req;
  logic [31:0] handler_pc;

  int n_chk;
  int n_pass;

  cp0_exc_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exc_valid  (exc_valid),
    .exc_code   (exc_code),
    .hw_int     (hw_int),
    .cp0_addr   (cp0_addr),
    .cp0_we     (cp0_we),
    .cp0_din    (cp0_din),
    .eret       (eret),
    .cp0_dout   (cp0_dout),
    .epc_out    (epc_out),
    .exc_req    (exc_req),
    .handler_pc (handler_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  tag, got, exp);
  endtask

  task automatic idle();
    pc_m      = '0;
    bd_m      = 1'b0;
    exc_valid = 1'b0;
    exc_code  = '0;
    hw_int    = '0;
    cp0_addr  = '0;
    cp0_we    = 1'b0;
    cp0_din   = '0;
    eret      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag,
                    input logic [4:0] a,
                    input logic [31:0] exp);
    cp0_addr = a;
    cp0_we   = 1'b0;
    #1;
    chk(tag, cp0_dout, exp);
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    cp0_addr = a;
    cp0_we   = 1'b1;
    cp0_din  = d;
    tick();
    cp0_we   = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    idle();
    repeat (3) tick();
    chk("rst_exc_req", {31'd0, exc_req}, 32'd0);
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    chk("rst_epc_out", epc_out, 32'd0);
    chk("handler_pc", handler_pc, 32'h0000_4180);
    reset_n = 1'b1;
    tick();

    // overflow entry
    exc_valid = 1'b1;
    exc_code  = 5'd12;
    pc_m      = 32'h0000_3010;
    #1;
    chk("ov_req", {31'd0, exc_req}, 32'd1);
    tick();
    #1;
    chk("ov_masked", {31'd0, exc_req}, 32'd0);
    rd("ov_sr", 5'd12, 32'h0000_0002);
    rd("ov_cause", 5'd13, 32'h0000_0030);
    rd("ov_epc", 5'd14, 32'h0000_3010);
    chk("ov_epc_out", epc_out, 32'h0000_3010);

    exc_valid = 1'b0;
    do_eret();
    rd("eret_sr", 5'd12, 32'd0);

    // delay-slot entry
    exc_valid = 1'b1;
    exc_code  = 5'd10;
    pc_m      = 32'h0000_3024;
    bd_m      = 1'b1;
    tick();
    exc_valid = 1'b0;
    bd_m      = 1'b0;
    rd("bd_epc", 5'd14, 32'h0000_3020);
    rd("bd_cause", 5'd13, 32'h8000_0028);
    do_eret();

    // EPC wrap for pc 0 in a delay slot
    exc_valid = 1'b1;
    exc_code  = 5'd4;
    pc_m      = 32'h0;
    bd_m      = 1'b1;
    tick();
    exc_valid = 1'b0;
    bd_m      = 1'b0;
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    do_eret();

    // mtc0 SR with read-during-write
    cp0_addr = 5'd12;
    cp0_we   = 1'b1;
    cp0_din  = 32'hFFFF_0401;
    #1;
    chk("rdw_sr_old", cp0_dout, 32'd0);
    tick();
    cp0_we = 1'b0;
    rd("sr_written", 5'd12, 32'h0000_0401);

    // interrupt entry
    hw_int = 6'b000001;
    pc_m   = 32'h0000_0100;
    #1;
    chk("int_req", {31'd0, exc_req}, 32'd1);
    tick();
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_epc", 5'd14, 32'h0000_0100);
    rd("int_sr", 5'd12, 32'h0000_0403);

    hw_int = 6'b000010;
    do_eret();
    #1;
    chk("int_unmasked", {31'd0, exc_req}, 32'd0);

    // interrupt beats exception
    hw_int    = 6'b000001;
    exc_valid = 1'b1;
    exc_code  = 5'd12;
    tick();
    exc_valid = 1'b0;
    hw_int    = 6'b0;
    rd("prio_cause", 5'd13, 32'h0000_0400);
    do_eret();

    // EPC write forces low bits to 0
    wr(5'd14, 32'h0000_3007);
    rd("epc_wr", 5'd14, 32'h0000_3004);
    chk("epc_wr_out", epc_out, 32'h0000_3004);

    // mtc0 discarded when entry happens
    hw_int   = 6'b000001;
    cp0_addr = 5'd12;
    cp0_we   = 1'b1;
    cp0_din  = 32'h0000_FC00;
    tick();
    cp0_we   = 1'b0;
    hw_int   = 6'b0;
    rd("wr_conflict_sr", 5'd12, 32'h0000_0403);

    rd("prid", 5'd15, 32'h0000_0001);
    rd("reg3", 5'd3, 32'd0);

    // reset during the handler
    exc_valid = 1'b1;
    reset_n   = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, exc_req}, 32'd0);
    rd("mid_rst_sr", 5'd13 - 5'd1, 32'd0);
    rd("mid_rst_cause", 5'd13, 32'd0);
    rd("mid_rst_epc", 5'd14, 32'd0);
    exc_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

`ifdef CP0_TIMER_EN
    wr(5'd11, 32'd20);
    wr(5'd12, 32'h0000_8001);
    wr(5'd9, 32'd15);
    repeat (5) tick();
    #1;
    chk("tmr_not_yet", {31'd0, exc_req}, 32'd0);
    tick();
    #1;
    chk("tmr_req", {31'd0, exc_req}, 32'd1);
    tick();
    rd("tmr_cause", 5'd13, 32'h0000_8000);
    rd("tmr_count", 5'd9, 32'd22);
    wr(5'd11, 32'd0);
    do_eret();
    #1;
    chk("tmr_cleared", {31'd0, exc_req}, 32'd0);
`else
    rd("no_count", 5'd9, 32'd0);
    wr(5'd11, 32'd20);
    rd("no_compare", 5'd11, 32'd0);
    wr(5'd12, 32'h0000_8001);
    hw_int = 6'b100000;
    #1;
    chk("hw5_req", {31'd0, exc_req}, 32'd1);
    hw_int = 6'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 style exception/interrupt unit at the consumer end of the execute-stage exception reporting (overflow and other exception codes raised by EX/M).
- Holds SR, Cause, EPC and PRId, and decides each cycle whether the M-stage instruction is replaced by an exception or interrupt entry.
- Services mfc0/mtc0/eret from the M stage.
- Drives the flush request and handler PC back to the pipeline.

Parameters:
- PRID, 32'h0000_0001, read-only value of PRId (reg 15)
- EXC_VECTOR, 32'h0000_4180, handler entry address driven on handler_pc

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- pc_m  in  32  PC of instruction in M stage
- bd_m  in  1  M-stage instruction is in a branch delay slot
- exc_valid  in  1  M-stage instruction carries an exception
- exc_code  in  5  ExcCode of that exception (12 = Ov, 4 = AdEL, 5 = AdES, 10 = RI)
- hw_int  in  6  external interrupt lines, level-sensitive
- cp0_addr  in  5  register number for mfc0/mtc0
- cp0_we  in  1  mtc0 write enable
- cp0_din  in  32  mtc0 write data
- eret  in  1  eret in M stage
- cp0_dout  out  32  combinational read of cp0_addr
- epc_out  out  32  current EPC register
- exc_req  out  1  take exception/interrupt this cycle (flush and redirect)
- handler_pc  out  32  constant EXC_VECTOR

Behaviour:
- SR (12):
  - IM = [15:10], EXL = [1], IE = [0]; all other bits read 0 and ignore writes.
  - Reset value 0.
- Cause (13):
  - BD = [31], IP = [15:10], ExcCode = [6:2]; other bits read 0.
  - IP is loaded every cycle with hw_int (timer override under option).
  - Cause is not writable by mtc0.
  - Reset value 0.
- EPC (14):
  - 32-bit, writable by mtc0; bits [1:0] always forced 0 on write.
  - Reset value 0.
- PRId (15): constant PRID.
- Other addresses read 0; writes to them are ignored.
- int_pend = |(hw_int & IM) & IE & ~EXL, combinational on current register values and current hw_int.
- exc_pend = exc_valid & ~EXL.
- exc_req = int_pend | exc_pend, combinational; forced 0 while reset_n is low.
- Priority: an interrupt wins over a simultaneous exception.
- On a rising edge with exc_req = 1:
  - EXL <= 1.
  - ExcCode <= int_pend ? 0 : exc_code.
  - BD <= bd_m.
  - EPC <= bd_m ? pc_m - 4 : pc_m (32-bit wrap, with pc_m = 0 and bd_m = 1 giving 32'hFFFF_FFFC).
- A simultaneous mtc0 is discarded when exc_req = 1, since the instruction is cancelled.
- eret with exc_req = 0: EXL <= 0 on the edge. When exc_req = 1, exception entry wins and eret is ignored.
- mtc0 with exc_req = 0 updates the target on the edge.
- The new SR affects int_pend from the next cycle only.
- Read-during-write: cp0_dout and epc_out show the old value in the write cycle and the new value after the edge. There is no internal bypass; pipeline forwarding handles this.
- Reset asserted mid-operation: all registers clear immediately; exc_req drops in the same cycle.
- Nested entry is impossible while EXL = 1: exceptions and interrupts are masked and exc_valid is dropped.

Optional Feature:
- Macro: CP0_TIMER_EN.
- With the macro:
  - Count (reg 9) increments by 1 every cycle and wraps at 32'hFFFF_FFFF -> 0; it is writable.
  - Compare (reg 11) is writable.
  - When Count == Compare and Compare != 0, a sticky timer_pend sets on the next edge.
  - timer_pend replaces hw_int[5] in IP[15] and in int_pend.
  - Any mtc0 to Compare clears timer_pend.
  - A Count write in the same cycle as an increment takes the written value.
  - Count, Compare and timer_pend reset to 0.
- Without the macro: regs 9/11 read 0, ignore writes, and hw_int[5] is used directly.

Test Plan:
- Overflow entry: reset; exc_valid = 1, exc_code = 12, pc_m = 32'h0000_3010, bd_m = 0 -> exc_req = 1 that cycle. Next cycle: EXL = 1, Cause[6:2] = 12, EPC = 32'h0000_3010, and exc_req = 0 even though exc_valid is still 1.
- Delay-slot entry: exc_valid = 1, exc_code = 10, pc_m = 32'h0000_3024, bd_m = 1 -> EPC = 32'h0000_3020, Cause[31] = 1.
- Interrupt masking and priority:
  - mtc0 SR = 32'h0000_0401 (IM[10] = 1, IE = 1), then hw_int = 6'b000001 -> exc_req = 1, ExcCode = 0.
  - hw_int = 6'b000010 alone -> exc_req = 0.
  - Interrupt together with exc_valid/exc_code = 12 -> ExcCode = 0.
- eret and write conflicts:
  - With EXL = 1, eret -> EXL = 0 next cycle.
  - mtc0 EPC = 32'h0000_3007 -> reads 32'h0000_3004.
  - mtc0 SR in the same cycle as exc_req -> SR is unchanged apart from EXL being set.
- Reads and reset:
  - mfc0 reg 15 -> PRID.
  - Reg 3 -> 0.
  - Assert reset_n = 0 mid-handler -> SR/Cause/EPC read 0 and exc_req = 0 immediately.
- Timer (CP0_TIMER_EN only):
  - Compare = 20, SR = 32'h0000_8001 -> timer_pend sets on the edge after Count equals 20, IP[15] = 1 and exc_req = 1.
  - mtc0 Compare clears it.
